demux_1an_registrado: RTL and testbench

Parametrised 1-to-N stream demultiplexer and the successor to the plain 1-to-2 combinational demux. One input stream is routed to one of CANALES output channels, or to all channels in broadcast mode. Each output channel has its own registered valid/ready stage, so a stalled channel does not block traffic bound for the others. Used wherever one producer feeds several independent consumers.

---
 rtl/demux_1an_registrado_if.sv | 30 +++
 rtl/demux_1an_registrado.sv | 102 ++++++++++
 tb/tb_demux_1an_registrado.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/demux_1an_registrado_if.sv
// Stream bundle for demux_1an_registrado: one input stream in, CANALES
// registered output channels out, plus the selector-error status.
interface demux_1an_registrado_if #(
  parameter int ANCHO   = 8,
  parameter int CANALES = 4,
  parameter int SEL_W   = 2
);
  logic                       in_valid;
  logic                       in_ready;
  logic [ANCHO-1:0]           in_data;
  logic [SEL_W-1:0]           in_sel;
  logic                       in_bcast;
  logic [CANALES-1:0]         out_valid;
  logic [CANALES-1:0]         out_ready;
  logic [CANALES*ANCHO-1:0]   out_data;
  logic                       err_sel;
  logic [7:0]                 drop_count;

  // Producer and consumers side (drives the input stream and channel readies).
  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, err_sel, drop_count
  );

  // Demux side.
  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, err_sel, drop_count
  );
endinterface

// File: rtl/demux_1an_registrado.sv
// 1-to-N stream demultiplexer with one registered valid/ready holding stage
// per output channel. Words go to the channel named by in_sel, or to every
// channel when in_bcast is set. Out-of-range selectors are accepted and
// dropped, flagged by an err_sel pulse and a saturating drop counter.
module demux_1an_registrado #(
  parameter int ANCHO   = 8,
  parameter int CANALES = 4,
  parameter int SEL_W   = 2
) (
  input logic clk,
  input logic rst,
  demux_1an_registrado_if.slave bus
);

  localparam logic [31:0] CANALES_U = CANALES;

  if (CANALES < 2 || CANALES > 16 || CANALES > (1 << SEL_W) || ANCHO < 1) begin : g_bad_params
    $error("demux_1an_registrado: need ANCHO>=1, 2<=CANALES<=16, CANALES<=2**SEL_W");
  end

  logic [CANALES-1:0]            valid_q, valid_d;
  logic [CANALES-1:0][ANCHO-1:0] data_q, data_d;
  logic                          err_q, err_d;
  logic [7:0]                    drop_q, drop_d;

  logic [CANALES-1:0] free;
  logic [CANALES-1:0] uni_hit;
  logic [CANALES-1:0] load;
  logic               sel_ok;
  logic               in_ready_c;
  logic               accept;
  logic               drop;

  // Readiness and per-channel load decode from the current inputs.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    free       = ~valid_q | bus.out_ready;
    sel_ok     = (32'(bus.in_sel) < CANALES_U);
    uni_hit    = '0;
    for (int i = 0; i < CANALES; i++) begin
      uni_hit[i] = !bus.in_bcast && (bus.in_sel == SEL_W'(i));
    end

    in_ready_c = 1'b0;
    if (!rst) begin
      if (bus.in_bcast)  in_ready_c = &free;
      else if (sel_ok)   in_ready_c = |(uni_hit & free);
      else               in_ready_c = 1'b1;  // bad selector: always swallowed
    end

    accept = bus.in_valid && in_ready_c;
    drop   = accept && !bus.in_bcast && !sel_ok;
    load   = '0;
    for (int i = 0; i < CANALES; i++) begin
      load[i] = accept && (bus.in_bcast || uni_hit[i]);
    end
  end

  // Next state of the holding registers and the error/drop status.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < CANALES; i++) begin
      if (load[i]) begin
        valid_d[i] = 1'b1;        // load wins over a simultaneous drain
        data_d[i]  = bus.in_data;
      end else if (valid_q[i] && bus.out_ready[i]) begin
        valid_d[i] = 1'b0;        // drained; data keeps its last value
      end
    end
    err_d  = drop;
    drop_d = drop_q;
    if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  // State registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      // NOTE: the data registers are reset too, because out_data must read
      // zero after reset, not merely be ignored while out_valid is low.
      data_q  <= '0;
      err_q   <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = valid_q;
  assign bus.out_data   = data_q;
  assign bus.err_sel    = err_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_demux_1an_registrado.sv
// Directed bench for demux_1an_registrado: a vector table on a 4-channel
// instance plus a hand-written invalid-selector sequence on a 3-channel one.
module tb_demux_1an_registrado;

  logic clk = 1'b0;
  logic rst4, rst3;
  always #5 clk = ~clk;

  demux_1an_registrado_if #(.ANCHO(8), .CANALES(4), .SEL_W(2)) bus4 ();
  demux_1an_registrado_if #(.ANCHO(8), .CANALES(3), .SEL_W(2)) bus3 ();

  demux_1an_registrado #(.ANCHO(8), .CANALES(4), .SEL_W(2)) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4.slave)
  );
  demux_1an_registrado #(.ANCHO(8), .CANALES(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst3), .bus(bus3.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        vld;
    logic        bc;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [3:0]  ordy;
    logic        exp_rdy;  // in_ready before the edge
    logic [3:0]  exp_ov;   // out_valid after the edge
    logic [31:0] exp_od;   // out_data after the edge
  } vec_t;

  function automatic vec_t mk(logic r, logic v, logic b, logic [1:0] s, logic [7:0] d,
                              logic [3:0] o, logic er, logic [3:0] eov, logic [31:0] eod);
    vec_t t;
    t.rst = r; t.vld = v; t.bc = b; t.sel = s; t.data = d; t.ordy = o;
    t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod;
    return t;
  endfunction

  vec_t tbl[22];

  initial begin
    // Reset with in_valid high, then unicast sweep.
    tbl[0]  = mk(1, 1, 0, 0, 8'hFF, 4'hF, 0, 4'b0000, 32'h00000000);
    tbl[1]  = mk(1, 1, 0, 0, 8'hFF, 4'hF, 0, 4'b0000, 32'h00000000);
    tbl[2]  = mk(0, 0, 0, 0, 8'hFF, 4'hF, 1, 4'b0000, 32'h00000000);
    tbl[3]  = mk(0, 1, 0, 0, 8'hA0, 4'hF, 1, 4'b0001, 32'h000000A0);
    tbl[4]  = mk(0, 1, 0, 1, 8'hA1, 4'hF, 1, 4'b0010, 32'h0000A1A0);
    tbl[5]  = mk(0, 1, 0, 2, 8'hA2, 4'hF, 1, 4'b0100, 32'h00A2A1A0);
    tbl[6]  = mk(0, 1, 0, 3, 8'hA3, 4'hF, 1, 4'b1000, 32'hA3A2A1A0);
    tbl[7]  = mk(0, 0, 0, 0, 8'h00, 4'hF, 1, 4'b0000, 32'hA3A2A1A0);
    // Backpressure isolation on channel 2.
    tbl[8]  = mk(0, 1, 0, 2, 8'hB0, 4'b1011, 1, 4'b0100, 32'hA3B0A1A0);
    tbl[9]  = mk(0, 1, 0, 2, 8'hB1, 4'b1011, 0, 4'b0100, 32'hA3B0A1A0);
    tbl[10] = mk(0, 1, 0, 1, 8'h55, 4'b1011, 1, 4'b0110, 32'hA3B055A0);
    tbl[11] = mk(0, 1, 0, 2, 8'hB1, 4'b1111, 1, 4'b0100, 32'hA3B155A0);
    tbl[12] = mk(0, 0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000, 32'hA3B155A0);
    // Broadcast blocked by a full, stalled channel 3.
    tbl[13] = mk(0, 1, 0, 3, 8'hC3, 4'b0111, 1, 4'b1000, 32'hC3B155A0);
    tbl[14] = mk(0, 1, 1, 0, 8'h3C, 4'b0111, 0, 4'b1000, 32'hC3B155A0);
    tbl[15] = mk(0, 1, 1, 0, 8'h3C, 4'b1111, 1, 4'b1111, 32'h3C3C3C3C);
    tbl[16] = mk(0, 0, 0, 0, 8'h00, 4'b0101, 1, 4'b1010, 32'h3C3C3C3C);
    tbl[17] = mk(0, 0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000, 32'h3C3C3C3C);
    // Reset while channels 0 and 1 hold stalled words.
    tbl[18] = mk(0, 1, 0, 0, 8'hD0, 4'b0000, 1, 4'b0001, 32'h3C3C3CD0);
    tbl[19] = mk(0, 1, 0, 1, 8'hD1, 4'b0000, 1, 4'b0011, 32'h3C3CD1D0);
    tbl[20] = mk(1, 0, 0, 0, 8'h00, 4'b0000, 0, 4'b0000, 32'h00000000);
    tbl[21] = mk(0, 0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000, 32'h00000000);

    rst4 = 1'b1; rst3 = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_bcast = 1'b0; bus4.in_sel = '0;
    bus4.in_data = '0; bus4.out_ready = '1;
    bus3.in_valid = 1'b0; bus3.in_bcast = 1'b0; bus3.in_sel = '0;
    bus3.in_data = '0; bus3.out_ready = '1;
    @(posedge clk); #1;

    // ---- table on the 4-channel instance ----
    for (int i = 0; i < 22; i++) begin
      rst4           = tbl[i].rst;
      bus4.in_valid  = tbl[i].vld;
      bus4.in_bcast  = tbl[i].bc;
      bus4.in_sel    = tbl[i].sel;
      bus4.in_data   = tbl[i].data;
      bus4.out_ready = tbl[i].ordy;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(bus4.in_ready), 32'(tbl[i].exp_rdy));
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i), 32'(bus4.out_valid), 32'(tbl[i].exp_ov));
      check($sformatf("v%0d out_data", i), bus4.out_data, tbl[i].exp_od);
      check($sformatf("v%0d err_sel", i), 32'(bus4.err_sel), 32'd0);
      check($sformatf("v%0d drop_count", i), 32'(bus4.drop_count), 32'd0);
    end
    bus4.in_valid = 1'b0;

    // ---- invalid selector on the 3-channel instance ----
    rst3 = 1'b0;
    check("c3 reset drop_count", 32'(bus3.drop_count), 32'd0);
    check("c3 reset err_sel", 32'(bus3.err_sel), 32'd0);
    bus3.in_valid = 1'b1; bus3.in_sel = 2'd3; bus3.in_data = 8'h77;
    #1;
    check("c3 bad sel in_ready", 32'(bus3.in_ready), 32'd1);
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    check("c3 drop out_valid", 32'(bus3.out_valid), 32'd0);
    check("c3 drop err_sel", 32'(bus3.err_sel), 32'd1);
    check("c3 drop count 1", 32'(bus3.drop_count), 32'd1);
    @(posedge clk); #1;
    check("c3 err_sel pulse ends", 32'(bus3.err_sel), 32'd0);
    check("c3 count holds", 32'(bus3.drop_count), 32'd1);

    // Valid selector still works on the 3-channel instance.
    bus3.in_valid = 1'b1; bus3.in_sel = 2'd2; bus3.in_data = 8'h9E;
    bus3.out_ready = 3'b000;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    check("c3 ch2 out_valid", 32'(bus3.out_valid), 32'b100);
    check("c3 ch2 out_data", 32'(bus3.out_data), 32'h9E0000);
    check("c3 ch2 no error", 32'(bus3.err_sel), 32'd0);

    // 260 further drops: the counter saturates at 255.
    bus3.in_valid = 1'b1; bus3.in_sel = 2'd3;
    for (int k = 0; k < 260; k++) begin
      @(posedge clk); #1;
    end
    bus3.in_valid = 1'b0;
    check("c3 saturated count", 32'(bus3.drop_count), 32'd255);
    check("c3 err during drops", 32'(bus3.err_sel), 32'd1);
    check("c3 ch2 held", 32'(bus3.out_valid), 32'b100);
    @(posedge clk); #1;
    check("c3 count stays 255", 32'(bus3.drop_count), 32'd255);
    check("c3 err clears", 32'(bus3.err_sel), 32'd0);

    // Reset clears counter and held word.
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0; bus3.out_ready = 3'b111;
    check("c3 rst drop_count", 32'(bus3.drop_count), 32'd0);
    check("c3 rst out_valid", 32'(bus3.out_valid), 32'd0);
    @(posedge clk); #1;
    check("c3 no ghost word", 32'(bus3.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
